// File: rtl/pc_unit.sv
// Registered program counter with STEP increment, load, and a LIFO return-address stack for call/ret.
// One prioritised command per cycle, 1-cycle latency, no backpressure; all outputs registered.
module pc_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STEP        = 1,
  parameter bit          SATURATE    = 1'b0,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ret,
  input  logic             call,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pc,
  output logic             ovf,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);

  localparam int unsigned     CW      = $clog2(STACK_DEPTH + 1);
  localparam logic [63:0]     STEP64  = 64'(STEP);
  localparam logic [WIDTH:0]  STEP_W  = STEP64[WIDTH:0];
  localparam logic [CW-1:0]   DEPTH_C = CW'(STACK_DEPTH);

  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pc_n;
  logic             ovf_n;
  logic             err_n;
  logic             push;

  // Return address and inc target share one adder, so call and inc agree on wrap/clamp.
  always_comb begin
    sum   = {1'b0, pc} + STEP_W;
    carry = sum[WIDTH];
    nxt   = (SATURATE && carry) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt == CW'(i + 1)) top = stack[i];
    end
  end

  always_comb begin
    pc_n  = pc;
    cnt_n = cnt;
    err_n = stk_err;
    ovf_n = 1'b0;
    push  = 1'b0;
    if (clr) begin
      pc_n  = '0;
      cnt_n = '0;
      err_n = 1'b0;
    end else if (ret) begin
      if (cnt != '0) begin
        pc_n  = top;
        cnt_n = cnt - CW'(1);
      end else begin
        err_n = 1'b1;
      end
    end else if (call) begin
      // Overflow is reported even when the push is rejected.
      ovf_n = carry;
      if (cnt != DEPTH_C) begin
        push  = 1'b1;
        pc_n  = din;
        cnt_n = cnt + CW'(1);
      end else begin
        err_n = 1'b1;
      end
    end else if (load) begin
      pc_n = din;
    end else if (inc) begin
      pc_n  = nxt;
      ovf_n = carry;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && cnt == CW'(i)) stack[i] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      stk_err   <= 1'b0;
      stk_empty <= 1'b1;
      stk_full  <= 1'b0;
    end else begin
      pc        <= pc_n;
      cnt       <= cnt_n;
      ovf       <= ovf_n;
      stk_err   <= err_n;
      stk_empty <= (cnt_n == '0);
      stk_full  <= (cnt_n == DEPTH_C);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: default instance (wrap, STEP=1) plus a saturating STEP=4 instance.
// Expected outputs are queued as each command is driven and compared once the edge has passed.
module tb_pc_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic        ovf;
    logic        emp;
    logic        full;
    logic        err;
  } exp_t;

  typedef struct packed {
    logic [4:0]  cmd;
    logic [15:0] din;
    exp_t        e;
  } step_t;

  localparam logic [4:0] HOLD = 5'b00000;
  localparam logic [4:0] CLR  = 5'b10000;
  localparam logic [4:0] RET  = 5'b01000;
  localparam logic [4:0] CALL = 5'b00100;
  localparam logic [4:0] LOAD = 5'b00010;
  localparam logic [4:0] INC  = 5'b00001;

  logic        clk;
  logic        rst_n;
  logic        clr, ret, call, load, inc;
  logic [15:0] din;
  logic [15:0] pc;
  logic        ovf, stk_empty, stk_full, stk_err;

  logic        s_clr, s_ret, s_call, s_load, s_inc;
  logic [15:0] s_din;
  logic [15:0] s_pc;
  logic        s_ovf, s_stk_empty, s_stk_full, s_stk_err;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  pc_unit #(.WIDTH(16), .STEP(1), .SATURATE(1'b0), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ret(ret), .call(call), .load(load), .inc(inc),
    .din(din), .pc(pc), .ovf(ovf), .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  pc_unit #(.WIDTH(16), .STEP(4), .SATURATE(1'b1), .STACK_DEPTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .ret(s_ret), .call(s_call), .load(s_load), .inc(s_inc),
    .din(s_din), .pc(s_pc), .ovf(s_ovf), .stk_empty(s_stk_empty), .stk_full(s_stk_full),
    .stk_err(s_stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(input logic [4:0] c, input logic [15:0] d,
                               input logic [15:0] p, input logic [3:0] f);
    step_t s;
    s.cmd    = c;
    s.din    = d;
    s.e.pc   = p;
    s.e.ovf  = f[3];
    s.e.emp  = f[2];
    s.e.full = f[1];
    s.e.err  = f[0];
    return s;
  endfunction

  function automatic exp_t obs();
    return '{pc: pc, ovf: ovf, emp: stk_empty, full: stk_full, err: stk_err};
  endfunction

  function automatic exp_t obs_sat();
    return '{pc: s_pc, ovf: s_ovf, emp: s_stk_empty, full: s_stk_full, err: s_stk_err};
  endfunction

  task automatic drive(input logic [4:0] c, input logic [15:0] d, input exp_t e);
    {clr, ret, call, load, inc} = c;
    din = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    {clr, ret, call, load, inc} = HOLD;
  endtask

  task automatic drive_sat(input logic [4:0] c, input logic [15:0] d, input exp_t e);
    {s_clr, s_ret, s_call, s_load, s_inc} = c;
    s_din = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    {s_clr, s_ret, s_call, s_load, s_inc} = HOLD;
  endtask

  task automatic test_reset();
    exp_t got, want;
    rst_n = 1'b0;
    {clr, ret, call, load, inc} = HOLD;
    {s_clr, s_ret, s_call, s_load, s_inc} = HOLD;
    din = '0;
    s_din = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(HOLD, 16'h0, 16'h0000, 4'b0100).e);
    got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
               got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_inc_wrap();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(INC,  16'h0000, 16'h0001, 4'b0100));
    s.push_back(mk(INC,  16'h0000, 16'h0002, 4'b0100));
    s.push_back(mk(INC,  16'h0000, 16'h0003, 4'b0100));
    s.push_back(mk(LOAD, 16'hFFFE, 16'hFFFE, 4'b0100));
    s.push_back(mk(INC,  16'h0000, 16'hFFFF, 4'b0100));
    s.push_back(mk(INC,  16'h0000, 16'h0000, 4'b1100));
    s.push_back(mk(HOLD, 16'h0000, 16'h0000, 4'b0100));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL inc_wrap[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_call_ret();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(CLR,  16'h0000, 16'h0000, 4'b0100));
    s.push_back(mk(LOAD, 16'h0010, 16'h0010, 4'b0100));
    s.push_back(mk(CALL, 16'h0100, 16'h0100, 4'b0000));
    s.push_back(mk(CALL, 16'h0200, 16'h0200, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h0101, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h0011, 4'b0100));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL call_ret[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_stack_err();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(CLR,  16'h0000, 16'h0000, 4'b0100));
    s.push_back(mk(CALL, 16'h1000, 16'h1000, 4'b0000));
    s.push_back(mk(CALL, 16'h2000, 16'h2000, 4'b0000));
    s.push_back(mk(CALL, 16'h3000, 16'h3000, 4'b0000));
    s.push_back(mk(CALL, 16'hFFFF, 16'hFFFF, 4'b0010));
    s.push_back(mk(CALL, 16'h5000, 16'hFFFF, 4'b1011));
    s.push_back(mk(RET,  16'h0000, 16'h3001, 4'b0001));
    s.push_back(mk(CLR,  16'h0000, 16'h0000, 4'b0100));
    s.push_back(mk(RET,  16'h0000, 16'h0000, 4'b0101));
    s.push_back(mk(HOLD, 16'h0000, 16'h0000, 4'b0101));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stack_err[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_priority();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(LOAD,     16'h0050, 16'h0050, 4'b0101));
    s.push_back(mk(CALL,     16'h0060, 16'h0060, 4'b0001));
    s.push_back(mk(5'b11111, 16'h0700, 16'h0000, 4'b0100));
    s.push_back(mk(5'b00111, 16'h0300, 16'h0300, 4'b0000));
    s.push_back(mk(5'b00011, 16'h0040, 16'h0040, 4'b0000));
    s.push_back(mk(5'b01011, 16'h0999, 16'h0001, 4'b0100));
    s.push_back(mk(5'b01001, 16'h0000, 16'h0001, 4'b0101));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL priority[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(CLR,  16'h0000, 16'h0000, 4'b0100));
    s.push_back(mk(LOAD, 16'h0020, 16'h0020, 4'b0100));
    s.push_back(mk(CALL, 16'h0080, 16'h0080, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h0021, 4'b0100));
    s.push_back(mk(CALL, 16'h00A0, 16'h00A0, 4'b0000));
    s.push_back(mk(CALL, 16'h00B0, 16'h00B0, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h00A1, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h0022, 4'b0100));
    s.push_back(mk(LOAD, 16'hFFFF, 16'hFFFF, 4'b0100));
    s.push_back(mk(CALL, 16'h0010, 16'h0010, 4'b1000));
    s.push_back(mk(RET,  16'h0000, 16'h0000, 4'b0100));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_saturate();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(INC,  16'h0000, 16'h0004, 4'b0100));
    s.push_back(mk(LOAD, 16'hFFFD, 16'hFFFD, 4'b0100));
    s.push_back(mk(INC,  16'h0000, 16'hFFFF, 4'b1100));
    s.push_back(mk(INC,  16'h0000, 16'hFFFF, 4'b1100));
    s.push_back(mk(HOLD, 16'h0000, 16'hFFFF, 4'b0100));
    s.push_back(mk(CALL, 16'h0010, 16'h0010, 4'b1000));
    s.push_back(mk(RET,  16'h0000, 16'hFFFF, 4'b0100));
    foreach (s[i]) begin
      drive_sat(s[i].cmd, s[i].din, s[i].e);
      got = obs_sat(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturate[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[$];
    exp_t got, want;
    s.push_back(mk(CLR,  16'h0000, 16'h0000, 4'b0100));
    s.push_back(mk(CALL, 16'h0100, 16'h0100, 4'b0000));
    s.push_back(mk(CALL, 16'h0200, 16'h0200, 4'b0000));
    s.push_back(mk(CALL, 16'h0300, 16'h0300, 4'b0000));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_setup[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
    // A call is pending when reset drops between edges; it must never complete.
    call = 1'b1;
    din  = 16'h0400;
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(HOLD, 16'h0, 16'h0000, 4'b0100).e);
    #1;
    got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_immediate: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
               got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
    end
    exp_q.push_back(mk(HOLD, 16'h0, 16'h0000, 4'b0100).e);
    @(posedge clk);
    #1;
    got = obs(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL async_held: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
               got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
    end
    call  = 1'b0;
    rst_n = 1'b1;
    s.delete();
    s.push_back(mk(CALL, 16'h0500, 16'h0500, 4'b0000));
    s.push_back(mk(RET,  16'h0000, 16'h0001, 4'b0100));
    foreach (s[i]) begin
      drive(s[i].cmd, s[i].din, s[i].e);
      got = obs(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL async_after[%0d]: got pc=%h ovf/emp/full/err=%b%b%b%b, expected pc=%h ovf/emp/full/err=%b%b%b%b",
                 i, got.pc, got.ovf, got.emp, got.full, got.err, want.pc, want.ovf, want.emp, want.full, want.err);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_inc_wrap();
    test_call_ret();
    test_stack_err();
    test_priority();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter with increment, load, and a return-address stack for call and return. It extends the 16-bit incrementer into a registered PC generator for the CPU fetch path. Each cycle it applies one prioritised command to the PC register and a LIFO stack, and it flags overflow and stack misuse. All outputs are registered.

## Interface
- WIDTH, 16: PC and data width in bits (2..32).
- STEP, 1: increment amount, constant, 1..2^WIDTH-1.
- SATURATE, 0: 0 = wrap modulo 2^WIDTH on overflow; 1 = clamp at all-ones.
- STACK_DEPTH, 4: return-stack entries (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear command.
- ret  in  1  return command: pop the stack into the PC.
- call  in  1  call command: push the return address, then jump to din.
- load  in  1  jump command: PC <= din.
- inc  in  1  advance command: PC <= PC + STEP.
- din  in  WIDTH  jump/call target.
- pc  out  WIDTH  current PC.
- ovf  out  1  one-cycle pulse: the last inc/call arithmetic overflowed.
- stk_empty  out  1  stack holds 0 entries.
- stk_full  out  1  stack holds STACK_DEPTH entries.
- stk_err  out  1  sticky error flag: push to a full stack or pop from an empty stack.

## Operation
- Command priority, one action per cycle: clr > ret > call > load > inc > hold.
- nxt = PC + STEP, computed at WIDTH+1 bits.
  - Carry out of bit WIDTH-1 is an overflow.
  - SATURATE=0: nxt truncated to WIDTH.
  - SATURATE=1: nxt clamped to 2^WIDTH-1.
- clr:
  - PC <= 0, stack count <= 0, stk_err <= 0, ovf <= 0.
  - Stack contents are don't-care after clr.
- ret:
  - Stack non-empty: PC <= top entry, count decrements.
  - Stack empty: PC holds, stk_err <= 1, count stays 0.
- call:
  - Stack not full: push nxt (return address, same SATURATE rule as inc), then PC <= din, count increments.
  - Stack full: no push, PC holds, stk_err <= 1.
  - ovf pulses if computing nxt overflowed, including on a rejected call.
- load: PC <= din. Stack is untouched.
- inc: PC <= nxt. ovf pulses on overflow, in both SATURATE modes.
- hold: no command asserted; state unchanged.
- Lower-priority commands asserted in the same cycle are ignored completely, with no side effects.
- stk_err stays set until clr or reset.
- stk_full and stk_empty are derived from the registered count.
- Stack storage is a register array plus a pointer; no RAM inference.

## Timing
- Every command takes effect at the rising clk edge where it is sampled. New pc, flags, and count are visible in the same cycle, after the edge.
- Latency is 1 cycle from command to pc.
- Back-to-back commands run every cycle with no bubbles:
  - call immediately followed by ret returns to the pushed address.
  - A push followed by a pop in consecutive cycles is legal.
- ovf is high for exactly the one cycle following the overflowing edge. Otherwise it is 0.
- Reset (rst_n low, asynchronous assert):
  - pc = 0, ovf = 0, stk_err = 0, stk_empty = 1, stk_full = 0, count = 0.
  - Reset takes effect immediately, even mid-sequence; no command pending at assertion completes.
- Reset deassertion is synchronised externally. The first command is sampled at the first rising edge after rst_n goes high.
- din is sampled only on edges where load or call wins priority.

## Test plan
- Reset/inc/wrap: reset, then inc ×3 -> pc 0,1,2,3. Load 16'hFFFE, then inc ×2 -> pc FFFF, then 0000. ovf high only in the cycle pc becomes 0000.
- Saturate: SATURATE=1, STEP=4. Load 16'hFFFD, inc -> pc FFFF with ovf pulse. Inc again -> pc FFFF with ovf pulse again.
- Call/ret nesting: pc=0x0010, call din=0x0100 -> pc 0100. Call din=0x0200 -> pc 0200. Ret -> pc 0101. Ret -> pc 0011. stk_empty=1, stk_err=0.
- Stack errors: STACK_DEPTH=4. Five calls -> 5th leaves pc unchanged, stk_full=1, stk_err=1. clr -> pc 0, stk_err 0, stk_empty 1. Ret on empty -> pc stays 0, stk_err=1.
- Priority: clr+ret+call+load+inc together -> pc 0, stack emptied. call+load+inc with din=0x0300 -> call semantics, count+1. load+inc with din=0x0040 -> pc 0040.
- Async reset mid-operation: after 3 calls, pull rst_n low between edges -> pc 0 and stk_empty 1 immediately. The next call after release pushes 0x0001.
